// File: rtl/ibex_rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin ALU/LSU merge onto one write port,
// plus an optional load scoreboard (define IBEX_RF_WB_SCOREBOARD_EN to enable).
module ibex_rf_wb_arbiter #(
    parameter bit          RV32E      = 1'b0,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alu_req_i,
    input  logic [4:0]            alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_wdata_i,
    output logic                  alu_gnt_o,

    input  logic                  lsu_req_i,
    input  logic [4:0]            lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_gnt_o,

    input  logic                  ld_issue_i,
    input  logic [4:0]            ld_issue_addr_i,

    input  logic [4:0]            raddr_a_i,
    input  logic [4:0]            raddr_b_i,
    output logic                  hazard_a_o,
    output logic                  hazard_b_o,

    output logic [4:0]            waddr_a_o,
    output logic [DATA_WIDTH-1:0] wdata_a_o,
    output logic                  we_a_o,

    output logic [31:0]           busy_o
);

    logic                  last_alu_q, last_alu_d;
    logic                  we_q,       we_d;
    logic [4:0]            waddr_q,    waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [31:0]           busy_q,     busy_d;

    logic alu_gnt;
    logic lsu_gnt;

    function automatic logic addr_writable(input logic [4:0] addr);
        return (addr != 5'd0) && !(RV32E && addr[4]);
    endfunction

    // On contention the side that did not win last time gets the port.
    assign alu_gnt   = alu_req_i & (~lsu_req_i | ~last_alu_q);
    assign lsu_gnt   = lsu_req_i & (~alu_req_i |  last_alu_q);
    assign alu_gnt_o = alu_gnt;
    assign lsu_gnt_o = lsu_gnt;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        last_alu_d = last_alu_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (alu_gnt || lsu_gnt) begin
            last_alu_d = alu_gnt;
            waddr_d    = alu_gnt ? alu_addr_i  : lsu_addr_i;
            wdata_d    = alu_gnt ? alu_wdata_i : lsu_wdata_i;
            we_d       = addr_writable(waddr_d);
        end
    end

`ifdef IBEX_RF_WB_SCOREBOARD_EN
    // Set is applied after clear so a same-cycle issue/retire on one register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (lsu_gnt) begin
            busy_d[lsu_addr_i] = 1'b0;
        end
        if (ld_issue_i && addr_writable(ld_issue_addr_i)) begin
            busy_d[ld_issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end
`else
    logic unused_ld_issue;
    assign unused_ld_issue = ^{ld_issue_i, ld_issue_addr_i};
    assign busy_d          = '0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            last_alu_q <= 1'b1;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
        end else begin
            last_alu_q <= last_alu_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    // A register is unsafe to read while a load is outstanding or its write is still in flight.
    assign hazard_a_o = (raddr_a_i != 5'd0) &&
                        (busy_q[raddr_a_i] || (we_q && (waddr_q == raddr_a_i)));
    assign hazard_b_o = (raddr_b_i != 5'd0) &&
                        (busy_q[raddr_b_i] || (we_q && (waddr_q == raddr_b_i)));

    assign waddr_a_o = waddr_q;
    assign wdata_a_o = wdata_q;
    assign we_a_o    = we_q;
    assign busy_o    = busy_q;

endmodule
